// File: rtl/pwm_breath_gen.sv
// Breathing-envelope duty source for the PWM LED stage: ramp up, hold, ramp down, hold.
// Latency: level/phase update on the tick edge; duty_cycle/cycle_done +1 clk with gamma.
// Backpressure: none; enable low freezes everything and clears the prescaler.
// Optional: define PWM_BREATH_GAMMA_EN for a registered square-law gamma stage.
module pwm_breath_gen #(
    parameter int PRESCALE   = 2048,
    parameter int STEP       = 1,
    parameter int HOLD_TICKS = 64,
    parameter int MAX_LEVEL  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [7:0] duty_cycle,
    output logic [1:0] phase,
    output logic       cycle_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    typedef enum logic [1:0] {
        HOLD_LOW  = 2'b00,
        RAMP_UP   = 2'b01,
        HOLD_HIGH = 2'b10,
        RAMP_DOWN = 2'b11
    } state_t;

    state_t         state;
    logic [PW-1:0]  pre_cnt;
    logic [HW-1:0]  hold_cnt;
    logic [7:0]     level;
    logic           done_raw;
    logic           tick;
    logic           hold_last;
    logic [8:0]     up_sum;

    // enable low takes priority over a pending tick
    assign tick      = enable && (pre_cnt == PW'(PRESCALE - 1));
    assign hold_last = (hold_cnt == HW'(HOLD_TICKS - 1));
    // 9-bit sum so the clamp sees overflow past 255 instead of a wrapped value
    assign up_sum    = {1'b0, level} + 9'(STEP);

    // prescaler: counts enabled clocks, parks at 0 while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (!enable || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // envelope state machine, advances only on ticks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HOLD_LOW;
            level    <= 8'd0;
            hold_cnt <= '0;
            done_raw <= 1'b0;
        end else begin
            done_raw <= 1'b0;
            if (tick) begin
                case (state)
                    HOLD_LOW: begin
                        if (hold_last) begin
                            hold_cnt <= '0;
                            state    <= RAMP_UP;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    RAMP_UP: begin
                        if (up_sum >= 9'(MAX_LEVEL)) begin
                            level <= 8'(MAX_LEVEL);
                            state <= HOLD_HIGH;
                        end else begin
                            level <= up_sum[7:0];
                        end
                    end
                    HOLD_HIGH: begin
                        if (hold_last) begin
                            hold_cnt <= '0;
                            state    <= RAMP_DOWN;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                    RAMP_DOWN: begin
                        // compare before subtracting so the level never underflows
                        if (level <= 8'(STEP)) begin
                            level    <= 8'd0;
                            state    <= HOLD_LOW;
                            done_raw <= 1'b1;
                        end else begin
                            level <= level - 8'(STEP);
                        end
                    end
                    default: state <= HOLD_LOW;
                endcase
            end
        end
    end

    assign phase = state;

`ifdef PWM_BREATH_GAMMA_EN
    logic [7:0] duty_q;
    logic       done_q;

    // square-law gamma, rounded up so only level 0 maps to 0; done delayed to stay aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= 8'd0;
            done_q <= 1'b0;
        end else begin
            duty_q <= 8'(((16'(level) * 16'(level)) + 16'd255) >> 8);
            done_q <= done_raw;
        end
    end

    assign duty_cycle = duty_q;
    assign cycle_done = done_q;
`else
    assign duty_cycle = level;
    assign cycle_done = done_raw;
`endif

endmodule
